// File: rtl/guard_remove_if.sv
// AXI-Stream link used on both sides of guard_remove.
//   tdata  : 32-bit sample, I in [15:0], Q in [31:16]
//   tvalid : beat valid (master -> slave)
//   tlast  : last beat of the frame (master -> slave)
//   tready : slave can accept (slave -> master)
interface guard_remove_if;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tlast;
    logic        tready;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/guard_remove.sv
// guard_remove: receive-side guard/cyclic-prefix remover for an OFDM sample stream.
// Frame layout: preamble, then repeated [guard, CP, FFT body] symbols. Guard samples
// are always dropped, CP samples are dropped when stripping, everything else is
// forwarded through one output register stage.
// Ports:
//   aclk, aresetn   : clock, synchronous active-low reset
//   s_axis          : received sample stream (slave)
//   m_axis          : forwarded sample stream (master)
//   i_guard_cycles  : guard samples per symbol (0 = none)
//   i_nfft          : FFT body length minus 1
//   i_cp_len        : 0 = no CP, otherwise CP length minus 1
//   i_strip_cp      : 1 drops the CP, 0 forwards it
//   o_sym_cnt       : completed symbols in the current frame (saturating)
//   o_err_tlast     : one-cycle pulse when an input tlast lands on a dropped sample
module guard_remove #(
    parameter int unsigned g_ILA          = 0,
    parameter int unsigned g_PREAMBLE_LEN = 4096
) (
    input  logic            aclk,
    input  logic            aresetn,
    guard_remove_if.slave   s_axis,
    guard_remove_if.master  m_axis,
    input  logic [31:0]     i_guard_cycles,
    input  logic [13:0]     i_nfft,
    input  logic [11:0]     i_cp_len,
    input  logic            i_strip_cp,
    output logic [15:0]     o_sym_cnt,
    output logic            o_err_tlast
);

    typedef enum logic [1:0] {
        S_PRE   = 2'd0,
        S_GUARD = 2'd1,
        S_CP    = 2'd2,
        S_BODY  = 2'd3
    } state_t;

    // Counter load for the preamble; unused when there is no preamble.
    localparam logic [31:0] PRE_LOAD = (g_PREAMBLE_LEN == 32'd0) ? 32'd0 : 32'(g_PREAMBLE_LEN - 32'd1);

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_t      state_r, state_nx_s, cur_state_s, entry_g_state_s, entry_c_state_s;
    logic [31:0] cnt_r, cnt_nx_s, cur_cnt_s, entry_g_cnt_s, entry_c_cnt_s;
    logic        frame_start_r, frame_start_nx_s;
    logic        clr_pend_r, clr_pend_nx_s;
    logic [31:0] guard_r, cfg_guard_s;
    logic [13:0] nfft_r, cfg_nfft_s;
    logic [11:0] cp_r, cfg_cp_s;
    logic        strip_r, cfg_strip_s;
    logic [15:0] sym_cnt_r, sym_nx_s, sym_base_s;
    logic        err_r, err_nx_s;
    logic [31:0] m_data_r, m_data_nx_s;
    logic        m_valid_r, m_valid_nx_s;
    logic        m_last_r, m_last_nx_s;
    logic        s_ready_s, acc_s, fwd_s, last_beat_s;

    assign s_ready_s     = ~m_valid_r | m_axis.tready;
    assign s_axis.tready = s_ready_s;
    assign m_axis.tdata  = m_data_r;
    assign m_axis.tvalid = m_valid_r;
    assign m_axis.tlast  = m_last_r;
    assign o_sym_cnt     = sym_cnt_r;
    assign o_err_tlast   = err_r;

    // Next-state, counter, symbol count and output-register update
    always_comb begin
        // The first beat of a frame uses the live config; later beats the latched copy.
        cfg_guard_s = frame_start_r ? i_guard_cycles : guard_r;
        cfg_nfft_s  = frame_start_r ? i_nfft         : nfft_r;
        cfg_cp_s    = frame_start_r ? i_cp_len       : cp_r;
        cfg_strip_s = frame_start_r ? i_strip_cp     : strip_r;

        // First non-empty state reached when entering the guard (body is never empty).
        if (cfg_guard_s != 32'd0) begin
            entry_g_state_s = S_GUARD;
            entry_g_cnt_s   = cfg_guard_s - 32'd1;
        end else if (cfg_cp_s != 12'd0) begin
            entry_g_state_s = S_CP;
            entry_g_cnt_s   = {20'd0, cfg_cp_s};
        end else begin
            entry_g_state_s = S_BODY;
            entry_g_cnt_s   = {18'd0, cfg_nfft_s};
        end

        // First non-empty state reached when entering the CP.
        if (cfg_cp_s != 12'd0) begin
            entry_c_state_s = S_CP;
            entry_c_cnt_s   = {20'd0, cfg_cp_s};
        end else begin
            entry_c_state_s = S_BODY;
            entry_c_cnt_s   = {18'd0, cfg_nfft_s};
        end

        // Without a preamble the frame's first beat already belongs to the guard
        // (or later), which is only known once the live config is visible.
        if (frame_start_r && (g_PREAMBLE_LEN == 32'd0)) begin
            cur_state_s = entry_g_state_s;
            cur_cnt_s   = entry_g_cnt_s;
        end else begin
            cur_state_s = state_r;
            cur_cnt_s   = cnt_r;
        end

        fwd_s       = (cur_state_s == S_PRE) | (cur_state_s == S_BODY) |
                      ((cur_state_s == S_CP) & ~cfg_strip_s);
        acc_s       = s_axis.tvalid & s_ready_s;
        last_beat_s = (cur_cnt_s == 32'd0);
        sym_base_s  = clr_pend_r ? 16'd0 : sym_cnt_r;

        state_nx_s       = state_r;
        cnt_nx_s         = cnt_r;
        frame_start_nx_s = frame_start_r;
        clr_pend_nx_s    = 1'b0;
        sym_nx_s         = sym_base_s;
        err_nx_s         = 1'b0;

        if (acc_s) begin
            frame_start_nx_s = 1'b0;
            if (s_axis.tlast) begin
                // Frame ends on any state; a full body on this beat still counts.
                state_nx_s       = S_PRE;
                cnt_nx_s         = PRE_LOAD;
                frame_start_nx_s = 1'b1;
                clr_pend_nx_s    = 1'b1;
                err_nx_s         = ~fwd_s;
                if ((cur_state_s == S_BODY) && last_beat_s) begin
                    sym_nx_s = sat_inc(sym_base_s);
                end else begin
                    sym_nx_s = sym_base_s;
                end
            end else if (last_beat_s) begin
                case (cur_state_s)
                    S_PRE: begin
                        state_nx_s = entry_g_state_s;
                        cnt_nx_s   = entry_g_cnt_s;
                    end
                    S_GUARD: begin
                        state_nx_s = entry_c_state_s;
                        cnt_nx_s   = entry_c_cnt_s;
                    end
                    S_CP: begin
                        state_nx_s = S_BODY;
                        cnt_nx_s   = {18'd0, cfg_nfft_s};
                    end
                    S_BODY: begin
                        state_nx_s = entry_g_state_s;
                        cnt_nx_s   = entry_g_cnt_s;
                        sym_nx_s   = sat_inc(sym_base_s);
                    end
                    default: begin
                        state_nx_s = S_PRE;
                        cnt_nx_s   = PRE_LOAD;
                    end
                endcase
            end else begin
                state_nx_s = cur_state_s;
                cnt_nx_s   = cur_cnt_s - 32'd1;
            end
        end else begin
            state_nx_s = state_r;
            cnt_nx_s   = cnt_r;
        end

        // Output register: load on a forwarded beat, drain on tready, else hold.
        if (acc_s && fwd_s) begin
            m_data_nx_s  = s_axis.tdata;
            m_valid_nx_s = 1'b1;
            m_last_nx_s  = s_axis.tlast;
        end else if (m_axis.tready) begin
            m_data_nx_s  = m_data_r;
            m_valid_nx_s = 1'b0;
            m_last_nx_s  = 1'b0;
        end else begin
            m_data_nx_s  = m_data_r;
            m_valid_nx_s = m_valid_r;
            m_last_nx_s  = m_last_r;
        end
    end

    // State, counter, config latch and output registers
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_r       <= S_PRE;
            cnt_r         <= PRE_LOAD;
            frame_start_r <= 1'b1;
            clr_pend_r    <= 1'b0;
            guard_r       <= 32'd0;
            nfft_r        <= 14'd0;
            cp_r          <= 12'd0;
            strip_r       <= 1'b0;
            sym_cnt_r     <= 16'd0;
            err_r         <= 1'b0;
            m_data_r      <= 32'd0;
            m_valid_r     <= 1'b0;
            m_last_r      <= 1'b0;
        end else begin
            state_r       <= state_nx_s;
            cnt_r         <= cnt_nx_s;
            frame_start_r <= frame_start_nx_s;
            clr_pend_r    <= clr_pend_nx_s;
            if (acc_s && frame_start_r) begin
                guard_r <= i_guard_cycles;
                nfft_r  <= i_nfft;
                cp_r    <= i_cp_len;
                strip_r <= i_strip_cp;
            end else begin
                guard_r <= guard_r;
                nfft_r  <= nfft_r;
                cp_r    <= cp_r;
                strip_r <= strip_r;
            end
            sym_cnt_r     <= sym_nx_s;
            err_r         <= err_nx_s;
            m_data_r      <= m_data_nx_s;
            m_valid_r     <= m_valid_nx_s;
            m_last_r      <= m_last_nx_s;
        end
    end

    generate
        if (g_ILA != 0) begin : g_ila
            // Debug probe bundle for the logic analyzer core: state, counters, both handshakes
            logic [89:0] probe_r;
            // Registered probe capture to keep the tap off the datapath timing
            always_ff @(posedge aclk) begin
                probe_r <= {state_r, cnt_r, sym_cnt_r, err_r,
                            s_axis.tvalid, s_ready_s, s_axis.tlast,
                            m_valid_r, m_axis.tready, m_last_r, m_data_r[31:16]};
            end
        end
    endgenerate

endmodule

// File: tb/tb_guard_remove.sv
// Directed bench for guard_remove: builds each frame from its known layout, derives
// which beats must appear on the output, and compares against a negedge monitor.
module tb_guard_remove;

    localparam int PRE = 4096;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [31:0] i_guard_cycles;
    logic [13:0] i_nfft;
    logic [11:0] i_cp_len;
    logic        i_strip_cp;
    logic [15:0] o_sym_cnt;
    logic        o_err_tlast;

    guard_remove_if s_if ();
    guard_remove_if m_if ();

    always #5 aclk = ~aclk;

    guard_remove #(.g_ILA(0), .g_PREAMBLE_LEN(PRE)) dut (
        .aclk           (aclk),
        .aresetn        (aresetn),
        .s_axis         (s_if),
        .m_axis         (m_if),
        .i_guard_cycles (i_guard_cycles),
        .i_nfft         (i_nfft),
        .i_cp_len       (i_cp_len),
        .i_strip_cp     (i_strip_cp),
        .o_sym_cnt      (o_sym_cnt),
        .o_err_tlast    (o_err_tlast)
    );

    int          errors   = 0;
    int          checks   = 0;
    int          err_seen = 0;
    bit          bp_en    = 1'b0;
    logic [32:0] got_q[$];
    logic [32:0] exp_q[$];
    bit          stall_r  = 1'b0;
    logic [32:0] held_r   = 33'd0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Whether input beat idx of a frame with the given layout reaches the output.
    function automatic bit keep_at(input int idx, input int g, input int c, input int n, input bit strip);
        int r;
        if (idx < PRE) return 1'b1;
        r = (idx - PRE) % (g + c + n);
        if (r < g) return 1'b0;
        if (r < g + c) return !strip;
        return 1'b1;
    endfunction

    // Output monitor: records consumed beats, checks stall stability, counts error pulses.
    always @(negedge aclk) begin
        if (aresetn !== 1'b1) begin
            stall_r = 1'b0;
        end else begin
            if (stall_r)
                check("hold_stable", {m_if.tvalid, m_if.tlast, m_if.tdata}, {1'b1, held_r});
            if (m_if.tvalid && m_if.tready)
                got_q.push_back({m_if.tlast, m_if.tdata});
            stall_r = m_if.tvalid && !m_if.tready;
            held_r  = {m_if.tlast, m_if.tdata};
            if (o_err_tlast) err_seen++;
        end
    end

    // Present one input beat until accepted; returns 1 time unit after the accepting edge.
    task automatic send(input logic [31:0] d, input logic l);
        int waitc;
        bit hs;
        waitc = 0;
        s_if.tdata  = d;
        s_if.tvalid = 1'b1;
        s_if.tlast  = l;
        forever begin
            m_if.tready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge aclk);
            hs = s_if.tready;
            @(posedge aclk);
            #1;
            if (hs || waitc > 200) break;
            waitc++;
        end
        check("send_wait", 64'(waitc > 200), 64'd0);
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
    endtask

    task automatic run_frame(input int fid, input int g, input int nfft, input int cpl,
                             input bit strip, input int nsym, input int cut);
        int c, n, total, last_idx, nsym_done, mm, lim;
        logic [31:0] d;
        c        = (cpl == 0) ? 0 : cpl + 1;
        n        = nfft + 1;
        total    = PRE + nsym * (g + c + n);
        last_idx = (cut < 0) ? total - 1 : cut;
        exp_q.delete();
        got_q.delete();
        err_seen       = 0;
        i_guard_cycles = 32'(g);
        i_nfft         = 14'(nfft);
        i_cp_len       = 12'(cpl);
        i_strip_cp     = strip;
        for (int i = 0; i <= last_idx; i++) begin
            d = {8'hC0, 8'(fid), 16'(i)};
            if (keep_at(i, g, c, n, strip)) exp_q.push_back({(i == last_idx), d});
            send(d, (i == last_idx));
            if (i == 0) begin
                check("first_beat_latency", {m_if.tvalid, m_if.tdata}, {1'b1, d});
                // Config is latched on the first beat; these must have no effect.
                i_guard_cycles = 32'd3;
                i_nfft         = 14'd7;
                i_cp_len       = 12'd0;
                i_strip_cp     = ~strip;
            end
        end
        nsym_done = (last_idx >= PRE) ? (last_idx + 1 - PRE) / (g + c + n) : 0;
        check("sym_cnt_at_tlast", o_sym_cnt, nsym_done);
        m_if.tready = 1'b1;
        @(posedge aclk);
        #1;
        check("sym_cnt_cleared", o_sym_cnt, 0);
        repeat (6) @(posedge aclk);
        #1;
        check("beat_count", got_q.size(), exp_q.size());
        lim = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        mm  = -1;
        for (int i = 0; i < lim; i++) begin
            if (mm < 0 && got_q[i] !== exp_q[i]) begin
                mm = i;
                $display("frame %0d beat %0d: observed %h expected %h", fid, i, got_q[i], exp_q[i]);
            end
        end
        check("first_bad_beat", mm, -1);
        check("err_pulses", err_seen, keep_at(last_idx, g, c, n, strip) ? 0 : 1);
    endtask

    initial begin
        aresetn        = 1'b0;
        s_if.tdata     = 32'd0;
        s_if.tvalid    = 1'b0;
        s_if.tlast     = 1'b0;
        m_if.tready    = 1'b1;
        i_guard_cycles = 32'd0;
        i_nfft         = 14'd0;
        i_cp_len       = 12'd0;
        i_strip_cp     = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        check("rst_tvalid", m_if.tvalid, 0);
        check("rst_tdata",  m_if.tdata,  0);
        check("rst_tlast",  m_if.tlast,  0);
        check("rst_sym_cnt", o_sym_cnt,  0);
        check("rst_err",    o_err_tlast, 0);
        check("rst_sready", s_if.tready, 1);
        aresetn = 1'b1;

        // Baseline: G=10, N=32, C=8, forward CP, 3 symbols.
        run_frame(1, 10, 31, 7, 1'b0, 3, -1);
        // Strip CP: 32 body samples per symbol.
        run_frame(2, 10, 31, 7, 1'b1, 3, -1);
        // No CP, no guard: pure pass-through.
        run_frame(3, 0, 31, 0, 1'b0, 2, -1);
        // Backpressure: random downstream ready.
        bp_en = 1'b1;
        run_frame(4, 10, 31, 7, 1'b0, 3, -1);
        bp_en = 1'b0;
        // Misaligned tlast on 5th guard sample of symbol 2.
        run_frame(5, 10, 31, 7, 1'b0, 3, PRE + 50 + 4);
        // Next frame restarts in preamble; tlast truncates symbol 3 inside its body.
        run_frame(6, 10, 31, 7, 1'b0, 3, PRE + 100 + 18 + 5);

        // Reset in the body of symbol 2 with an output beat pending.
        i_guard_cycles = 32'd10;
        i_nfft         = 14'd31;
        i_cp_len       = 12'd7;
        i_strip_cp     = 1'b0;
        for (int i = 0; i <= PRE + 50 + 30; i++) send({8'hC0, 8'd7, 16'(i)}, 1'b0);
        check("sym_cnt_mid", o_sym_cnt, 1);
        check("pending_beat", m_if.tvalid, 1);
        m_if.tready = 1'b0;
        aresetn     = 1'b0;
        @(posedge aclk);
        #1;
        check("rst_mid_tvalid", m_if.tvalid, 0);
        check("rst_mid_sym_cnt", o_sym_cnt, 0);
        aresetn     = 1'b1;
        m_if.tready = 1'b1;
        run_frame(8, 10, 31, 7, 1'b0, 3, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/guard_remove.md
# guard_remove

Receive-side counterpart of the transmit guard inserter. Accepts a received OFDM sample stream laid out as preamble, then repeated [guard, cyclic prefix, FFT body] symbols, and discards the guard interval (and optionally the cyclic prefix) so downstream FFT logic sees contiguous symbol samples. Sits between the receive front-end sample stream and the FFT/CP-removal path, with AXI-Stream on both sides.

## Interface

Parameters:
- g_ILA, 0, 1 instantiates a debug ILA on the state, counters and both AXI-Stream handshakes; 0 omits it.
- g_PREAMBLE_LEN, 4096, preamble samples forwarded unchanged at frame start; 0 means no preamble.

Ports:
- aclk  in  1  clock, all logic on the rising edge.
- aresetn  in  1  synchronous, active-low reset.
- s_axis_tdata  in  32  received sample, I in [15:0], Q in [31:16]; passed through unmodified.
- s_axis_tvalid  in  1  input sample valid.
- s_axis_tlast  in  1  last sample of the frame.
- s_axis_tready  out  1  input ready.
- m_axis_tdata  out  32  forwarded sample.
- m_axis_tvalid  out  1  output valid.
- m_axis_tlast  out  1  end of frame on the output.
- m_axis_tready  in  1  downstream ready.
- i_guard_cycles  in  32  guard samples per symbol G; 0 means no guard.
- i_nfft  in  14  FFT body length minus 1 (31 means N = 32).
- i_cp_len  in  12  0 means no CP; otherwise CP length C = i_cp_len + 1.
- i_strip_cp  in  1  1 drops the CP; 0 forwards CP + body.
- o_sym_cnt  out  16  completed symbols in the current frame.
- o_err_tlast  out  1  one-cycle pulse when input tlast lands on a dropped sample.

## Operation

- Latch i_guard_cycles, i_nfft, i_cp_len and i_strip_cp on the first accepted sample of a frame. Config changes mid-frame have no effect until the next frame.
- States:
  - S_PRE: forward g_PREAMBLE_LEN samples.
  - S_GUARD: drop G samples.
  - S_CP: drop C samples if strip is set, otherwise forward them.
  - S_BODY: forward N samples.
- A 32-bit down-counter is loaded on each state entry and decremented per accepted input beat. The state advances on the beat where the counter reaches its last value.
- Transitions:
  - S_PRE → S_GUARD.
  - S_GUARD → S_CP.
  - S_CP → S_BODY.
  - S_BODY → S_GUARD, and o_sym_cnt increments (saturates at 0xFFFF).
- Zero-length states are skipped in the same cycle:
  - G = 0 skips S_GUARD.
  - i_cp_len = 0 skips S_CP.
  - g_PREAMBLE_LEN = 0 makes the frame start in S_GUARD (or the next non-empty state).
- Input beat with tlast, in any state: the FSM returns to S_PRE, counters reload, and o_sym_cnt clears on the next cycle.
  - If the beat is forwarded, m_axis_tlast = 1 on that output beat.
  - If the beat is dropped, no output beat is produced and o_err_tlast pulses for one cycle.
- Truncated final symbol (tlast inside S_BODY before N samples): the beat is forwarded with tlast and o_sym_cnt does not increment.

## Timing

- Reset values: m_axis_tvalid = 0, m_axis_tdata = 0, m_axis_tlast = 0, o_sym_cnt = 0, o_err_tlast = 0, state = S_PRE, counter loaded for the preamble.
- s_axis_tready = !m_axis_tvalid | m_axis_tready, in every state; dropped beats obey the same ready.
- One output register stage: a forwarded beat accepted in cycle k appears on m_axis in cycle k+1 and is held until m_axis_tready = 1.
- Sustains 1 sample/clock with m_axis_tready held high. Output has gaps of exactly G (+ C when stripping) cycles per symbol.
- m_axis_tdata, m_axis_tvalid and m_axis_tlast are stable while m_axis_tvalid = 1 and m_axis_tready = 0.
- Reset mid-frame: all outputs and state return to reset values on the next edge; a pending output beat is discarded.
- Counter width: G up to 2^32 − 1 is supported. N up to 16384 and C up to 4096 use the same counter.

## Test plan

- Baseline:
  - Stimulus: G = 10, i_nfft = 31, i_cp_len = 7, strip = 0, 4096 preamble samples, then 3 symbols (50 samples each), tlast on the final sample.
  - Required: output = 4096 preamble + 3×40 samples in order, m_axis_tlast on the last output beat only, o_sym_cnt = 3 before clearing.
- Strip CP:
  - Stimulus: same as baseline with strip = 1.
  - Required: exactly 32 output samples per symbol, equal to input body values 9..40 of each symbol; o_err_tlast = 0.
- No CP, no guard:
  - Stimulus: i_cp_len = 0, G = 0, 2 symbols of 32.
  - Required: pure pass-through of all 4096 + 64 samples with 1-cycle latency.
- Backpressure:
  - Stimulus: m_axis_tready toggling at a pseudo-random 50% duty cycle.
  - Required: output sequence identical to the baseline, no duplicated or lost beats, tdata stable while stalled.
- Misaligned tlast:
  - Stimulus: tlast on the 5th guard sample of symbol 2.
  - Required: o_err_tlast pulses once, no output tlast, next frame restarts correctly in S_PRE.
- Reset mid-symbol:
  - Stimulus: aresetn low for 1 cycle during S_BODY.
  - Required: m_axis_tvalid = 0 and o_sym_cnt = 0 the following cycle, then a subsequent full frame is processed correctly.
